es_io_port: RTL and testbench
=============================

Name: es_io_port

Overview:
- I/O peripheral at the far end of the CPU's IN/OUT instructions.
- Responds to the control unit's IN cycle by supplying a word from an external producer, held in a single-entry input register.
- Responds to the OUT cycle by queueing the CPU word into a small FIFO that an external consumer drains over a valid/ready handshake.
- Exposes a status word and sticky error flags at a second I/O address.

Parameters:
DATA_W, 16, CPU data word width
ADDR_W, 7, I/O address width (instruction operand field)
OUT_DEPTH, 4, output FIFO entries (power of two, >=2)
BASE_ADDR, 7'h7E, data port address; status port is BASE_ADDR+1

Ports:
clk  in  1  single system clock, all state on rising edge
reset  in  1  synchronous, active-high
io_addr  in  ADDR_W  I/O address of current IN/OUT
io_rd  in  1  IN strobe, one cycle per instruction
io_wr  in  1  OUT strobe, one cycle per instruction
io_wdata  in  DATA_W  CPU data for OUT
io_rdata  out  DATA_W  data for IN, combinational, valid while io_rd=1
in_valid  in  1  external producer offers in_data
in_ready  out  1  input register empty
in_data  in  DATA_W  producer word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data
out_data  out  DATA_W  FIFO head word

Behaviour:
- Reset, one clk edge with reset=1: FIFO empty, input register empty, flags cleared. in_ready=1, out_valid=0, out_data=0. Same result mid-transfer: pending words are discarded.
- Address decode: hit_d = (io_addr==BASE_ADDR), hit_s = (io_addr==BASE_ADDR+1). Strobes to other addresses are ignored, and io_rdata=0.
- Input register (states EMPTY/FULL):
  - EMPTY: in_valid=1 loads in_data and moves to FULL.
  - FULL: io_rd & hit_d returns the held word and moves to EMPTY at the edge.
  - in_ready = (state==EMPTY). There is no bypass, so a producer push and a CPU pop cannot complete in the same cycle on an empty register.
  - A CPU read of the data port while EMPTY returns 0 and sets sticky udf.
- Output FIFO, circular, OUT_DEPTH entries:
  - Pointers are log2(OUT_DEPTH) bits and wrap modulo OUT_DEPTH. count is log2(OUT_DEPTH)+1 bits.
  - io_wr & hit_d pushes io_wdata.
  - Pop occurs on out_valid & out_ready.
  - Full and pop in the same cycle: the push is accepted and count is unchanged.
  - Full and no pop: the write is dropped and sticky ovf is set.
  - Empty and push: out_valid rises the next cycle (no fall-through).
  - out_data = mem[rd_ptr], stable while out_valid=1 and out_ready=0.
- Status word (io_rd & hit_s), LSB first:
  - bit0 in_full
  - bit1 out_empty
  - bit2 out_full
  - bit3 udf
  - bit4 ovf
  - bits[7:5] count, zero-extended to 3 bits
  - remaining bits 0
- Status write (io_wr & hit_s): write-1-to-clear on bits 3 and 4. Other bits are ignored. If a clear and a set of the same flag occur in the same cycle, set wins.
- io_rd and io_wr asserted together are illegal. The block ignores io_wr in that cycle.
- Latency:
  - CPU read: 0 cycles (combinational).
  - CPU write to out_valid: 1 cycle.
  - Producer to readable: 1 cycle.

Decomposition:
- Shared package holds:
  - status bit index constants (ST_IN_FULL=0 … ST_COUNT_LSB=5)
  - opcode constants for IN (4'b1110) and OUT (4'b1111), shared with the control unit
- Sub-module es_sync_fifo (parameters DATA_W, DEPTH) implements the output queue: push/pop/full/empty/count.
- The top level holds address decode, the input register FSM, and the flags.

Test Plan:
- Reset, then producer drives in_valid=1, in_data=16'hBEEF. Required: in_ready=0 the next cycle. IN at 7'h7E returns 16'hBEEF, and in_ready=1 the following cycle.
- IN at 7'h7E with the register empty. Required: io_rdata=0. Status read at 7'h7F shows bit3=1. OUT 16'h0008 to 7'h7F clears bit3.
- out_ready=0 and five OUTs of 1..5. Required: status count=4, out_full=1, ovf=1. Then out_ready=1 drains 1,2,3,4 in order, one per cycle.
- FIFO full with out_ready=1 plus an OUT of 16'h00AA in the same cycle. Required: count stays 4, ovf stays 0, and 16'h00AA appears last.
- Ten push/pop pairs to exercise pointer wrap. Required: output sequence equals input sequence.
- Reset asserted with FIFO count=3 and input register full. Required: next cycle out_valid=0, in_ready=1, and status reads 16'h0002.

Source files
------------

// File: rtl/es_io_port_pkg.sv
// Shared constants for the es_io_port I/O peripheral.
// Status bit positions, IN/OUT opcodes and input-register states.
package es_io_port_pkg;

  localparam int ST_IN_FULL   = 0;
  localparam int ST_OUT_EMPTY = 1;
  localparam int ST_OUT_FULL  = 2;
  localparam int ST_UDF       = 3;
  localparam int ST_OVF       = 4;
  localparam int ST_COUNT_LSB = 5;
  localparam int ST_COUNT_W   = 3;

  localparam logic [3:0] OP_IN  = 4'b1110;
  localparam logic [3:0] OP_OUT = 4'b1111;

  localparam logic [0:0] IN_EMPTY = 1'b0;
  localparam logic [0:0] IN_FULL  = 1'b1;

endpackage

// File: rtl/es_sync_fifo.sv
// Circular synchronous FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module es_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_pop;
  logic              w_push;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign rdata  = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: rdata is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/es_io_port.sv
// CPU IN/OUT peripheral: single-entry input register, output FIFO,
// status word with write-1-to-clear sticky error flags.
module es_io_port
  import es_io_port_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 7,
  parameter int                OUT_DEPTH = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 7'h7E
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic              io_rd,
  input  logic              io_wr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] STAT_ADDR = BASE_ADDR + 1'b1;

  logic [0:0]        r_in_state;
  logic [DATA_W-1:0] r_in_data;
  logic              r_udf;
  logic              r_ovf;

  logic              w_hit_d;
  logic              w_hit_s;
  logic              w_rd_d;
  logic              w_rd_s;
  logic              w_wr_d;
  logic              w_wr_s;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic [CW-1:0]     w_count;
  logic              w_udf_set;
  logic              w_ovf_set;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rdata;

  assign w_hit_d = (io_addr == BASE_ADDR);
  assign w_hit_s = (io_addr == STAT_ADDR);
  assign w_rd_d  = io_rd & w_hit_d;
  assign w_rd_s  = io_rd & w_hit_s;
  // A write strobe coinciding with a read is discarded.
  assign w_wr_d  = io_wr & ~io_rd & w_hit_d;
  assign w_wr_s  = io_wr & ~io_rd & w_hit_s;

  assign w_pop     = out_valid & out_ready;
  assign out_valid = ~w_empty;
  assign in_ready  = (r_in_state == IN_EMPTY);

  assign w_udf_set = w_rd_d & (r_in_state == IN_EMPTY);
  assign w_ovf_set = w_wr_d & w_full & ~w_pop;

  es_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_wr_d),
    .pop   (w_pop),
    .wdata (io_wdata),
    .rdata (out_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_state <= IN_EMPTY;
      r_in_data  <= '0;
    end else begin
      unique case (r_in_state)
        IN_EMPTY: if (in_valid) begin
          r_in_state <= IN_FULL;
          r_in_data  <= in_data;
        end
        IN_FULL: if (w_rd_d) r_in_state <= IN_EMPTY;
        default: r_in_state <= IN_EMPTY;
      endcase
    end
  end

  // Set has priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_udf <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_udf_set)
        r_udf <= 1'b1;
      else if (w_wr_s & io_wdata[ST_UDF])
        r_udf <= 1'b0;
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_wr_s & io_wdata[ST_OVF])
        r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_status = '0;
    w_status[ST_IN_FULL]   = (r_in_state == IN_FULL);
    w_status[ST_OUT_EMPTY] = w_empty;
    w_status[ST_OUT_FULL]  = w_full;
    w_status[ST_UDF]       = r_udf;
    w_status[ST_OVF]       = r_ovf;
    w_status[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(w_count);
  end

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_rd_d: w_rdata = (r_in_state == IN_FULL) ? r_in_data : '0;
      w_rd_s: w_rdata = w_status;
      default: w_rdata = '0;
    endcase
  end

  assign io_rdata = w_rdata;

endmodule

// File: tb/tb_es_io_port.sv
// Bench for es_io_port: directed scenarios followed by random traffic
// checked against a queue-based model of the peripheral.
module tb_es_io_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  io_addr;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int total = 0;
  int bad   = 0;

  logic [15:0] q[$];
  logic        m_in_full;
  logic [15:0] m_in_word;
  logic        m_udf;
  logic        m_ovf;

  always #5 clk = ~clk;

  es_io_port #(
    .DATA_W    (16),
    .ADDR_W    (7),
    .OUT_DEPTH (4),
    .BASE_ADDR (7'h7E)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .io_addr   (io_addr),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_in(input logic [6:0] a, output logic [15:0] d);
    io_addr = a;
    io_rd   = 1'b1;
    #1;
    d = io_rdata;
    tick();
    io_rd = 1'b0;
  endtask

  task automatic cpu_out(input logic [6:0] a, input logic [15:0] d);
    io_addr  = a;
    io_wdata = d;
    io_wr    = 1'b1;
    tick();
    io_wr = 1'b0;
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = '0;
    s[0]   = m_in_full;
    s[1]   = (q.size() == 0);
    s[2]   = (q.size() == 4);
    s[3]   = m_udf;
    s[4]   = m_ovf;
    s[7:5] = 3'(q.size());
    return s;
  endfunction

  task automatic rcycle();
    int          op;
    int          n;
    logic        rd;
    logic        wr;
    logic        pop;
    logic        push;
    logic [15:0] exp_rd;
    op = $urandom_range(0, 5);
    rd = (op == 1) || (op == 3);
    wr = (op == 2) || (op == 3) || (op == 5);
    io_rd = rd;
    io_wr = wr;
    case ($urandom_range(0, 3))
      0, 1:    io_addr = 7'h7E;
      2:       io_addr = 7'h7F;
      default: io_addr = 7'h05;
    endcase
    io_wdata  = 16'($urandom);
    in_valid  = 1'($urandom_range(0, 1));
    in_data   = 16'($urandom);
    out_ready = ($urandom_range(0, 2) != 0);
    reset     = ($urandom_range(0, 39) == 0);
    #1;
    exp_rd = '0;
    if (rd && io_addr == 7'h7E)
      exp_rd = m_in_full ? m_in_word : 16'h0;
    else if (rd && io_addr == 7'h7F)
      exp_rd = m_status();
    chk("rnd_rdata", io_rdata, exp_rd);
    chk("rnd_in_ready", {15'b0, in_ready}, {15'b0, !m_in_full});
    chk("rnd_out_valid", {15'b0, out_valid}, {15'b0, q.size() != 0});
    chk("rnd_out_data", out_data, (q.size() != 0) ? q[0] : 16'h0);
    n    = q.size();
    pop  = (n > 0) && out_ready;
    push = wr && !rd && io_addr == 7'h7E;
    if (reset) begin
      q.delete();
      m_in_full = 1'b0;
      m_udf     = 1'b0;
      m_ovf     = 1'b0;
    end else begin
      if (rd && io_addr == 7'h7E && !m_in_full)
        m_udf = 1'b1;
      else if (wr && !rd && io_addr == 7'h7F && io_wdata[3])
        m_udf = 1'b0;
      if (push && n == 4 && !pop)
        m_ovf = 1'b1;
      else if (wr && !rd && io_addr == 7'h7F && io_wdata[4])
        m_ovf = 1'b0;
      if (m_in_full) begin
        if (rd && io_addr == 7'h7E) m_in_full = 1'b0;
      end else if (in_valid) begin
        m_in_full = 1'b1;
        m_in_word = in_data;
      end
      if (pop) void'(q.pop_front());
      if (push && (n < 4 || pop)) q.push_back(io_wdata);
    end
    tick();
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] exp_q[$];
    reset     = 1'b1;
    io_addr   = '0;
    io_rd     = 1'b0;
    io_wr     = 1'b0;
    io_wdata  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_in_ready", {15'b0, in_ready}, 16'h1);
    chk("rst_out_valid", {15'b0, out_valid}, 16'h0);
    chk("rst_out_data", out_data, 16'h0);
    cpu_in(7'h7F, d);
    chk("rst_status", d, 16'h0002);

    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    tick();
    in_valid = 1'b0;
    chk("load_in_ready", {15'b0, in_ready}, 16'h0);
    cpu_in(7'h7E, d);
    chk("in_word", d, 16'hBEEF);
    chk("in_ready_after_rd", {15'b0, in_ready}, 16'h1);

    cpu_in(7'h7E, d);
    chk("udf_rdata", d, 16'h0);
    cpu_in(7'h7F, d);
    chk("udf_status", d, 16'h000A);
    cpu_out(7'h7F, 16'h0008);
    cpu_in(7'h7F, d);
    chk("udf_cleared", d, 16'h0002);

    cpu_in(7'h05, d);
    chk("other_addr_rd", d, 16'h0);

    for (int i = 1; i <= 5; i++) cpu_out(7'h7E, 16'(i));
    cpu_in(7'h7F, d);
    chk("ovf_status", d, 16'h0094);
    cpu_out(7'h7F, 16'h0010);
    out_ready = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", {15'b0, out_valid}, 16'h1);
      chk("drain_data", out_data, 16'(i));
      tick();
    end
    chk("drained_empty", {15'b0, out_valid}, 16'h0);
    out_ready = 1'b0;

    cpu_out(7'h7E, 16'h0011);
    cpu_out(7'h7E, 16'h0022);
    cpu_out(7'h7E, 16'h0033);
    cpu_out(7'h7E, 16'h0044);
    out_ready = 1'b1;
    io_addr   = 7'h7E;
    io_wdata  = 16'h00AA;
    io_wr     = 1'b1;
    #1;
    chk("fullpop_head", out_data, 16'h0011);
    tick();
    io_wr     = 1'b0;
    out_ready = 1'b0;
    cpu_in(7'h7F, d);
    chk("fullpop_status", d, 16'h0084);
    out_ready = 1'b1;
    exp_q = '{16'h0022, 16'h0033, 16'h0044, 16'h00AA};
    foreach (exp_q[k]) begin
      chk("fullpop_order", out_data, exp_q[k]);
      tick();
    end
    chk("fullpop_empty", {15'b0, out_valid}, 16'h0);

    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      io_addr  = 7'h7E;
      io_wdata = 16'($urandom);
      io_wr    = 1'b1;
      #1;
      if (i > 0) chk("wrap_data", out_data, exp_q[i-1]);
      exp_q.push_back(io_wdata);
      tick();
    end
    io_wr = 1'b0;
    chk("wrap_last", out_data, exp_q[9]);
    tick();
    chk("wrap_empty", {15'b0, out_valid}, 16'h0);
    out_ready = 1'b0;

    cpu_out(7'h7E, 16'h0101);
    cpu_out(7'h7E, 16'h0202);
    cpu_out(7'h7E, 16'h0303);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    in_valid = 1'b0;
    cpu_in(7'h7F, d);
    chk("pre_rst_status", d, 16'h0061);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_out_valid", {15'b0, out_valid}, 16'h0);
    chk("mid_rst_in_ready", {15'b0, in_ready}, 16'h1);
    chk("mid_rst_out_data", out_data, 16'h0);
    cpu_in(7'h7F, d);
    chk("mid_rst_status", d, 16'h0002);

    q.delete();
    m_in_full = 1'b0;
    m_in_word = '0;
    m_udf     = 1'b0;
    m_ovf     = 1'b0;
    for (int i = 0; i < 400; i++) rcycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
